// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous input (clkin) in clk cycles.
// clkin is synchronised and rising-edge detected. A counter runs between successive edges,
// and each completed period is presented on a valid/ready port. Overrun and timeout are
// reported as sticky flags.
// Optional feature macro: CLK_PERIOD_METER_HIGH_TIME_EN adds a high_time output. high_time
// counts the cycles the synced clkin was high during the measured period. It is captured and
// handshaked together with period.
module clk_period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clkin,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             timeout,
  input  logic             clear_flags
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [WIDTH-1:0] high_time
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_dly;
  logic                   sync_q;
  logic                   rise;
  logic [WIDTH-1:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0]       result;
  logic                   publish;
  logic                   tmo_evt;

  // Synchroniser shift chain plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      sync_dly  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], clkin};
      sync_dly  <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign sync_q = sync_pipe[SYNC_STAGES-1];
  assign rise   = sync_q & ~sync_dly;

  // State and period counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. An edge arriving on the saturation cycle still counts as a result,
  // so the published value is clamped instead of wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    publish   = 1'b0;
    tmo_evt   = 1'b0;
    result    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = ARM;
      end
      ARM: begin
        cnt_nxt = '0;
        if (!enable)   state_nxt = IDLE;
        else if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (rise) begin
          publish = 1'b1;
          cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
          tmo_evt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ARM;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Result register and valid/ready handshake. A new publish always wins over consumption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period       <= '0;
      period_valid <= 1'b0;
    end else if (publish) begin
      period       <= result;
      period_valid <= 1'b1;
    end else if (period_ready) begin
      period_valid <= 1'b0;
    end
  end

  // Sticky flags. A set event takes priority over clear_flags in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (publish && period_valid && !period_ready) overrun <= 1'b1;
      else if (clear_flags)                         overrun <= 1'b0;
      if (tmo_evt)          timeout <= 1'b1;
      else if (clear_flags) timeout <= 1'b0;
    end
  end

`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] hcnt;

  // High-time counter. The edge cycle itself is high, so the counter restarts at 1. Each
  // following MEASURE cycle adds the synced level, and the counter saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hcnt <= '0;
    else if (rise && state_nxt == MEASURE)
      hcnt <= WIDTH'(1);
    else if (state == MEASURE && sync_q && hcnt != CNT_MAX)
      hcnt <= hcnt + 1'b1;
  end

  // Capture high time alongside period so that both share one valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       high_time <= '0;
    else if (publish) high_time <= hcnt;
  end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter.
// The stimulus pushes expected results into a scoreboard queue. A monitor pops and compares
// the queue on every accepted output. Flags and reset state are checked directly.
module tb_clk_period_meter;

  localparam int W = 6;  // saturation at 63 keeps the timeout cases short

  logic         clk;
  logic         reset;
  logic         enable;
  logic         clkin;
  logic [W-1:0] period;
  logic         period_valid;
  logic         period_ready;
  logic         overrun;
  logic         timeout;
  logic         clear_flags;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
  logic [W-1:0] high_time;
`endif

  clk_period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clkin        (clkin),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .clear_flags  (clear_flags)
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
    ,
    .high_time    (high_time)
`endif
  );

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one clkin period: hi cycles high, then lo cycles low.
  task automatic wave(input int hi, input int lo);
    clkin = 1'b1;
    cyc(hi);
    clkin = 1'b0;
    cyc(lo);
  endtask

  task automatic push(input int p, input int h);
    exp_t e;
    e.p = p;
    e.h = h;
    sb.push_back(e);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && period_valid && period_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got period %0d, required no result", period);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_period", period, mon_e.p);
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
        chk("sb_high_time", high_time, mon_e.h);
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; clkin = 1'b0; period_ready = 1'b0; clear_flags = 1'b0;
    cyc(3);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b1;
    cyc(2);

    // Divided-by-8 clock, always ready: first edge arms, then one result of 8 per edge.
    period_ready = 1'b1; enable = 1'b1;
    cyc(2);
    repeat (3) push(8, 4);
    repeat (4) wave(4, 4);
    cyc(2);
    enable = 1'b0;
    cyc(2);
    chk("t1_drained", sb.size(), 0);

    // 20-cycle clkin, consumer stalled: results overwrite, overrun after the 2nd result.
    period_ready = 1'b0; enable = 1'b1;
    cyc(1);
    repeat (2) wave(10, 10);
    chk("t2_valid_1st", period_valid, 1);
    chk("t2_period_1st", period, 20);
    chk("t2_no_overrun", overrun, 0);
    wave(10, 10);
    chk("t2_overrun", overrun, 1);
    wave(10, 10);
    chk("t2_period_held", period, 20);
    push(20, 10);
    period_ready = 1'b1;
    cyc(2);
    chk("t2_valid_drop", period_valid, 0);
    chk("t2_overrun_sticky", overrun, 1);
    pulse_clear();
    chk("t2_overrun_clr", overrun, 0);
    enable = 1'b0;
    cyc(2);
    chk("t2_drained", sb.size(), 0);

    // Arm, then hold clkin low: counter saturates at 63, then timeout and return to ARM.
    enable = 1'b1;
    cyc(1);
    wave(4, 70);
    chk("t3_timeout", timeout, 1);
    chk("t3_valid", period_valid, 0);
    push(6, 3);
    repeat (2) wave(3, 3);
    cyc(4);
    enable = 1'b0;
    cyc(2);
    chk("t3_drained", sb.size(), 0);
    pulse_clear();
    chk("t3_timeout_clr", timeout, 0);

    // Edge on the saturation cycle: 64-cycle period yields 63 and no timeout.
    enable = 1'b1;
    cyc(1);
    push(63, 4);
    wave(4, 60);
    wave(4, 4);
    enable = 1'b0;
    cyc(2);
    chk("sat_no_timeout", timeout, 0);
    chk("sat_drained", sb.size(), 0);

    // 65-cycle period: saturation happens first, giving a timeout and no result.
    enable = 1'b1;
    cyc(1);
    wave(4, 61);
    wave(4, 4);
    enable = 1'b0;
    cyc(2);
    chk("sat65_timeout", timeout, 1);
    chk("sat65_no_result", period_valid, 0);
    pulse_clear();

    // Enable dropped mid-period: the partial period is discarded, so the next edge only arms.
    enable = 1'b1;
    cyc(1);
    wave(5, 2);
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(1);
    push(10, 5);
    repeat (2) wave(5, 5);
    enable = 1'b0;
    cyc(2);
    chk("t4_drained", sb.size(), 0);

    // Asynchronous reset mid-MEASURE with a valid result and overrun pending.
    period_ready = 1'b0; enable = 1'b1;
    cyc(1);
    repeat (3) wave(4, 4);
    chk("t5_pre_valid", period_valid, 1);
    chk("t5_pre_overrun", overrun, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_async_period", period, 0);
    chk("t5_async_valid", period_valid, 0);
    chk("t5_async_overrun", overrun, 0);
    cyc(2);
    reset = 1'b1; period_ready = 1'b1;
    cyc(2);
    push(8, 4);
    repeat (2) wave(4, 4);
    enable = 1'b0;
    cyc(2);
    chk("t5_rearm_drained", sb.size(), 0);

    // 3 high / 5 low: period 8, high time 3.
    enable = 1'b1;
    cyc(1);
    push(8, 3);
    repeat (2) wave(3, 5);
    enable = 1'b0;
    cyc(2);
    chk("t6_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
